hilo_muldiv_unit: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair for the EX stage of the pipelined MIPS CPU.
- Executes mult/multu, div/divu, madd/maddu and msub/msubu, plus single-cycle mthi/mtlo.
- Presents `busy` so the hazard logic stalls mfhi/mflo and any further muldiv op until the result is written.
- Adds divide support, which the current decoder leaves unimplemented.

---
 rtl/hilo_muldiv_if.sv | 17 +
 rtl/hilo_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// magnitude datapath with a single sign-fix cycle before the HI/LO write.
//
// state | meaning
// IDLE  | accepts start; mthi/mtlo write directly
// CALC  | one product/quotient bit per cycle, WIDTH cycles
// FIX   | sign correction, accumulate, HI/LO write
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0] OP_MTHI = 4'd8;
    localparam logic [3:0] OP_MTLO = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sgn_res_q, sgn_res_d;
    logic              sgn_rem_q, sgn_rem_d;
    logic [W2-1:0]     work_q, work_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  araw_q, araw_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    logic              a_neg, b_neg, is_div;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH:0]    mul_sum, div_shift, div_sub;
    logic              div_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [W2-1:0]     calc_work, prod_s, mul_res;
    logic [WIDTH-1:0]  quo_s, rem_s;

    // Even op codes in 0-7 are the signed variants.
    assign a_neg = bus.a[WIDTH-1] & ~bus.op[0];
    assign b_neg = bus.b[WIDTH-1] & ~bus.op[0];
    assign a_abs = a_neg ? -bus.a : bus.a;
    assign b_abs = b_neg ? -bus.b : bus.b;
    assign is_div = (op_q[2:1] == 2'b01);

    assign mul_sum   = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opb_q};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign rem_next  = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign calc_work = is_div ? {rem_next, work_q[WIDTH-2:0], div_ge}
                              : {mul_sum, work_q[WIDTH-1:1]};

    assign prod_s = sgn_res_q ? -work_q : work_q;
    assign quo_s  = sgn_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem_s  = sgn_rem_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];

    always_comb begin
        mul_res = prod_s;
        case (op_q)
            3'd4, 3'd5: mul_res = {hi_q, lo_q} + prod_s;
            3'd6, 3'd7: mul_res = {hi_q, lo_q} - prod_s;
            default:    mul_res = prod_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sgn_res_d = sgn_res_q;
        sgn_rem_d = sgn_rem_q;
        work_d    = work_q;
        opb_d     = opb_q;
        araw_d    = araw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (!bus.op[3]) begin
                        op_d      = bus.op[2:0];
                        sgn_res_d = a_neg ^ b_neg;
                        sgn_rem_d = a_neg;
                        work_d    = {{WIDTH{1'b0}}, a_abs};
                        opb_d     = b_abs;
                        araw_d    = bus.a;
                        cnt_d     = '0;
                        state_d   = S_CALC;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = calc_work;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div) begin
                        {hi_d, lo_d} = mul_res;
                    end else if (opb_q == '0) begin
                        // Zero divisor: report the untouched dividend, quotient saturated.
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sgn_res_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            work_q    <= '0;
            opb_q     <= '0;
            araw_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sgn_res_q <= sgn_res_d;
            sgn_rem_q <= sgn_rem_d;
            work_q    <= work_d;
            opb_q     <= opb_d;
            araw_q    <= araw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: 32-bit instance for the main sequence, 8-bit instance for the width check.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(32)) m32 ();
    hilo_muldiv_if #(.WIDTH(8))  m8 ();

    hilo_muldiv_unit #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(m32.slave));
    hilo_muldiv_unit #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(m8.slave));

    int checks = 0;
    int failures = 0;
    int nb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents the request for exactly one cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        m32.start = 1'b1;
        m32.op    = op;
        m32.a     = a;
        m32.b     = b;
        @(negedge clk);
        m32.start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (m32.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Issues an iterative op and stops at the negedge where done is expected high.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        check({tag, "_done_lo"}, m32.done, 1'b0);
        wait_idle(n);
        check({tag, "_cycles"}, n, 33);
        check({tag, "_done"}, m32.done, 1'b1);
        check({tag, "_hi"}, m32.hi, exp_hi);
        check({tag, "_lo"}, m32.lo, exp_lo);
    endtask

    initial begin
        m32.start = 1'b0; m32.op = '0; m32.a = '0; m32.b = '0; m32.flush = 1'b0;
        m8.start  = 1'b0; m8.op  = '0; m8.a  = '0; m8.b  = '0; m8.flush  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", m32.busy, 1'b0);
        check("rst_done", m32.done, 1'b0);
        check("rst_hi", m32.hi, 32'h0);
        check("rst_lo", m32.lo, 32'h0);

        // Back-to-back chain: each run issues in the done cycle of the previous one.
        run("mult",    4'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div",     4'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu",    4'd3, 32'd100,       32'd7,        32'd2,         32'd14);
        run("divu0",   4'd3, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
        run("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        @(negedge clk);
        check("done_pulse", m32.done, 1'b0);

        issue(4'd8, 32'h0, 32'h0);
        issue(4'd9, 32'hFFFF_FFFF, 32'h0);
        check("mtlo_busy", m32.busy, 1'b0);
        check("mtlo_lo", m32.lo, 32'hFFFF_FFFF);
        run("maddu", 4'd5, 32'd1, 32'd1, 32'd1, 32'd0);
        issue(4'd8, 32'h0, 32'h0);
        issue(4'd9, 32'h0, 32'h0);
        run("msubu", 4'd7, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // -1 - (-2 * 3) = 5
        run("msub", 4'd6, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h5);
        @(negedge clk);

        // Abort in CALC.
        issue(4'd8, 32'h11, 32'h0);
        issue(4'd9, 32'h22, 32'h0);
        issue(4'd0, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        m32.flush = 1'b1;
        @(negedge clk);
        m32.flush = 1'b0;
        check("flush_busy", m32.busy, 1'b0);
        check("flush_done", m32.done, 1'b0);
        @(negedge clk);
        check("flush_done2", m32.done, 1'b0);
        check("flush_hi", m32.hi, 32'h11);
        check("flush_lo", m32.lo, 32'h22);

        // start held during busy must not land as an mthi.
        issue(4'd5, 32'd3, 32'd4);
        m32.start = 1'b1; m32.op = 4'd8; m32.a = 32'hDEAD;
        repeat (5) @(negedge clk);
        m32.start = 1'b0;
        check("held_hi_mid", m32.hi, 32'h11);
        wait_idle(nb);
        check("held_hi", m32.hi, 32'h11);
        check("held_lo", m32.lo, 32'h2E);
        @(negedge clk);

        // flush with start in IDLE, and a reserved op.
        m32.flush = 1'b1;
        issue(4'd8, 32'h55, 32'h0);
        issue(4'd0, 32'd3, 32'd4);
        m32.flush = 1'b0;
        check("idle_flush_busy", m32.busy, 1'b0);
        check("idle_flush_hi", m32.hi, 32'h11);
        issue(4'd12, 32'h77, 32'h1);
        check("rsvd_busy", m32.busy, 1'b0);
        check("rsvd_hi", m32.hi, 32'h11);
        check("rsvd_lo", m32.lo, 32'h2E);

        // Reset mid-divide.
        issue(4'd2, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy", m32.busy, 1'b0);
        check("rstmid_done", m32.done, 1'b0);
        check("rstmid_hi", m32.hi, 32'h0);
        check("rstmid_lo", m32.lo, 32'h0);

        // 8-bit instance.
        m8.start = 1'b1; m8.op = 4'd0; m8.a = 8'hFD; m8.b = 8'h07;
        @(negedge clk);
        m8.start = 1'b0;
        nb = 0;
        while (m8.busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        check("w8_cycles", nb, 9);
        check("w8_done", m8.done, 1'b1);
        check("w8_hi", m8.hi, 8'hFF);
        check("w8_lo", m8.lo, 8'hEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
